// File: rtl/gpr_wb_queue_pkg.sv
// Shared constants for the GPR writeback queue: register-file geometry and
// the default queue depth.
package gpr_wb_queue_pkg;

   localparam int GPR_AW   = 5;
   localparam int GPR_DW   = 32;
   localparam int WB_DEPTH = 4;

   localparam logic [GPR_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/gpr_wb_match.sv
// Youngest-match search over the pending writeback entries for one hazard
// query address; the entry closest to the tail wins.
module gpr_wb_match
   import gpr_wb_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = GPR_AW,
   parameter int DW    = GPR_DW,
   localparam int PW   = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]         valid_i,
   input  logic [DEPTH-1:0][AW-1:0] rw_i,
   input  logic [DEPTH-1:0][DW-1:0] wd_i,
   input  logic [PW-1:0]            head_i,
   input  logic [AW-1:0]            query_i,
   output logic                     hit_o,
   output logic [DW-1:0]            data_o
);

   logic [PW-1:0] idx;

   // Walk from oldest (head) to youngest so the last hit overrides earlier ones.
   always_comb begin
      hit_o  = 1'b0;
      data_o = '0;
      idx    = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_i + PW'(i);
         if (valid_i[idx] && (rw_i[idx] == query_i)) begin
            hit_o  = 1'b1;
            data_o = wd_i[idx];
         end
      end
      if (query_i == AW'(REG_ZERO)) begin
         hit_o  = 1'b0;
         data_o = '0;
      end
   end

endmodule

// File: rtl/gpr_wb_queue.sv
// Writeback queue feeding the single GPR write port: buffers multi-cycle unit
// results, drains one per cycle, and answers busy/forward queries for two reads.
module gpr_wb_queue
   import gpr_wb_queue_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH,
   parameter int AW    = GPR_AW,
   parameter int DW    = GPR_DW,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] in_rw,
   input  logic [DW-1:0] in_wd,
   input  logic          hold,
   output logic          GPRWr,
   output logic [AW-1:0] rw,
   output logic [DW-1:0] wd,
   input  logic [AW-1:0] qa,
   input  logic [AW-1:0] qb,
   output logic          busy_a,
   output logic          busy_b,
   output logic [DW-1:0] fwd_a,
   output logic [DW-1:0] fwd_b,
   output logic [CW-1:0] count
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DEPTH-1:0][AW-1:0] rw_q;
   logic [DEPTH-1:0][DW-1:0] wd_q;
   logic [DEPTH-1:0]         valid_q;
   logic [PW-1:0]            head_q, head_d;
   logic [PW-1:0]            tail_q, tail_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     accept;
   logic                     enq;
   logic                     pop;

   // Writes to r0 still handshake but never occupy an entry.
   always_comb begin
      in_ready = (count_q < FULL_CNT);
      accept   = in_valid && in_ready;
      enq      = accept && (in_rw != AW'(REG_ZERO));
      pop      = (count_q != '0) && !hold;

      head_d = head_q;
      tail_d = tail_q;
      if (pop) begin
         head_d = head_q + 1'b1;
      end
      if (enq) begin
         tail_d = tail_q + 1'b1;
      end

      count_d = count_q;
      case ({enq, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pop and push never hit the same slot: pushing needs room, popping needs data.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rw_q    <= '0;
         wd_q    <= '0;
         valid_q <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         if (pop) begin
            valid_q[head_q] <= 1'b0;
         end
         if (enq) begin
            valid_q[tail_q] <= 1'b1;
            rw_q[tail_q]    <= in_rw;
            wd_q[tail_q]    <= in_wd;
         end
      end
   end

   always_comb begin
      GPRWr = pop;
      rw    = pop ? rw_q[head_q] : '0;
      wd    = pop ? wd_q[head_q] : '0;
      count = count_q;
   end

   gpr_wb_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_match_a (
      .valid_i (valid_q),
      .rw_i    (rw_q),
      .wd_i    (wd_q),
      .head_i  (head_q),
      .query_i (qa),
      .hit_o   (busy_a),
      .data_o  (fwd_a)
   );

   gpr_wb_match #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_match_b (
      .valid_i (valid_q),
      .rw_i    (rw_q),
      .wd_i    (wd_q),
      .head_i  (head_q),
      .query_i (qb),
      .hit_o   (busy_b),
      .data_o  (fwd_b)
   );

endmodule
